zero_flag_pipe: RTL and testbench

Pipelined, parametrised successor to the CPU's combinational 64-bit zero detector. It sits after the ALU result mux and computes per-lane and whole-word zero flags through a registered 4-ary reduction tree, so no reduction level lies on the ALU critical path. It carries N/C/V alongside the data and updates an architectural NZCV flag register when a flag-setting instruction retires from the pipe.

---
 rtl/zero_flag_pkg.sv | 58 +++++
 rtl/zero_flag_pipe_reduce4_stage.sv | 60 ++++++
 rtl/zero_flag_pipe.sv | 119 +++++++++++
 tb/tb_zero_flag_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zero_flag_pkg.sv
// Shared constants, types and elaboration-time helpers for the pipelined zero detector.
package zero_flag_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Reduction operator selector for one tree level.
    localparam bit OP_NOR = 1'b0;
    localparam bit OP_AND = 1'b1;

    typedef logic [3:0] flags_t;

    // Per-result sideband that rides alongside the reduction tree.
    typedef struct packed {
        logic n;
        logic c;
        logic v;
        logic set_flags;
    } sideband_t;

    // Number of 4-ary levels needed to reduce n bits to one: ceil(log4(n)).
    function automatic int clog4(input int n);
        int d;
        int span;
        d = 0;
        span = 1;
        for (int i = 0; i < 16; i++) begin
            if (span < n) begin
                span = span * 4;
                d = d + 1;
            end
        end
        return d;
    endfunction

    // Width of tree level k when level 0 is n bits wide.
    function automatic int level_width(input int n, input int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

    // Bit offset of level k inside a flat vector holding levels 0, 1, 2, ...
    function automatic int level_offset(input int n, input int k);
        int ofs;
        ofs = 0;
        for (int i = 0; i < k; i++) begin
            ofs = ofs + level_width(n, i);
        end
        return ofs;
    endfunction

endpackage

// File: rtl/zero_flag_pipe_reduce4_stage.sv
// One registered level of the 4-ary zero-detect tree, with its stage valid bit.
// Short trailing groups are padded with the operator's neutral value.
module reduce4_stage
    import zero_flag_pkg::*;
#(
    parameter int N_IN = 4,
    parameter bit OP   = OP_NOR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      prev_valid,
    input  logic [N_IN-1:0]           prev_bits,
    output logic                      valid,
    output logic [(N_IN+3)/4-1:0]     reduced
);

    localparam int   N_OUT = (N_IN + 3) / 4;
    localparam logic PAD   = (OP == OP_AND);

    logic [4*N_OUT-1:0] padded;
    logic [N_OUT-1:0]   next_reduced;

    // Pad the input up to a whole number of groups of four.
    always_comb begin
        padded = {(4*N_OUT){PAD}};
        padded[N_IN-1:0] = prev_bits;
    end

    // Reduce each group of four with NOR (first level) or AND (later levels).
    always_comb begin
        next_reduced = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (OP == OP_AND) begin
                next_reduced[i] = &padded[4*i +: 4];
            end else begin
                next_reduced[i] = ~|padded[4*i +: 4];
            end
        end
    end

    // Stage valid: flush kills whatever is being captured this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else begin
            valid <= prev_valid && !flush;
        end
    end

    // Stage data advances every cycle; stale values behind a bubble are harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            reduced <= '0;
        end else begin
            reduced <= next_reduced;
        end
    end

endmodule

// File: rtl/zero_flag_pipe.sv
// Pipelined per-lane and whole-word zero detector with NZCV flag register.
// Each lane runs a D-level registered 4-ary tree, followed by one merge stage.
module zero_flag_pipe
    import zero_flag_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  data,
    input  logic              carry_in,
    input  logic              overflow_in,
    input  logic              set_flags,
    input  logic              flush,
    output logic              out_valid,
    output logic [LANES-1:0]  lane_zero,
    output logic              zero,
    output logic [3:0]        flags
);

    localparam int LW      = WIDTH / LANES;
    localparam int D       = clog4(LW);
    localparam int TOTAL   = level_offset(LW, D + 1);
    localparam int OFS_TOP = level_offset(LW, D);

    logic [LANES-1:0] lane_tree;
    logic [LANES-1:0] lane_valid;
    logic             tree_valid;

    sideband_t sb_pipe [D];
    sideband_t sb_out;

    genvar l, k;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            // All tree levels of this lane packed back to back, level 0 = raw data.
            logic [TOTAL-1:0] tree;
            logic [D:0]       lvl_valid;

            assign tree[0 +: LW] = data[l*LW +: LW];
            assign lvl_valid[0]  = in_valid;

            for (k = 1; k <= D; k++) begin : g_lvl
                localparam int W_IN    = level_width(LW, k - 1);
                localparam int W_OUT   = level_width(LW, k);
                localparam int OFS_IN  = level_offset(LW, k - 1);
                localparam int OFS_OUT = level_offset(LW, k);

                reduce4_stage #(
                    .N_IN (W_IN),
                    .OP   ((k == 1) ? OP_NOR : OP_AND)
                ) u_stage (
                    .clk        (clk),
                    .reset      (reset),
                    .flush      (flush),
                    .prev_valid (lvl_valid[k-1]),
                    .prev_bits  (tree[OFS_IN +: W_IN]),
                    .valid      (lvl_valid[k]),
                    .reduced    (tree[OFS_OUT +: W_OUT])
                );
            end

            assign lane_tree[l]  = tree[OFS_TOP];
            assign lane_valid[l] = lvl_valid[D];
        end
    endgenerate

    // Every lane carries an identical valid chain.
    assign tree_valid = &lane_valid;

    // Sideband shift register, in lockstep with the tree levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                sb_pipe[i] <= '0;
            end
        end else begin
            sb_pipe[0].n         <= data[WIDTH-1];
            sb_pipe[0].c         <= carry_in;
            sb_pipe[0].v         <= overflow_in;
            sb_pipe[0].set_flags <= set_flags;
            for (int i = 1; i < D; i++) begin
                sb_pipe[i] <= sb_pipe[i-1];
            end
        end
    end

    // Merge stage: lane results and whole-word zero; holds outside valid results.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            lane_zero <= '0;
            zero      <= 1'b0;
            sb_out    <= '0;
        end else begin
            out_valid <= tree_valid && !flush;
            if (tree_valid && !flush) begin
                lane_zero <= lane_tree;
                zero      <= &lane_tree;
                sb_out    <= sb_pipe[D-1];
            end
        end
    end

    // Architectural NZCV register, written when a flag-setting result retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else if (out_valid && sb_out.set_flags && !flush) begin
            flags[FLAG_N] <= sb_out.n;
            flags[FLAG_Z] <= zero;
            flags[FLAG_C] <= sb_out.c;
            flags[FLAG_V] <= sb_out.v;
        end
    end

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Directed bench for zero_flag_pipe: three configurations driven in parallel.
module tb_zero_flag_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] data64;
    logic [39:0] data40;
    logic        carry_in;
    logic        overflow_in;
    logic        set_flags;
    logic        flush;

    logic        ov64, zero64;
    logic [0:0]  lanes64;
    logic [3:0]  flags64;
    logic        ov4, zero4;
    logic [3:0]  lanes4;
    logic [3:0]  flags4;
    logic        ov40, zero40;
    logic [0:0]  lanes40;
    logic [3:0]  flags40;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] mflags;

    zero_flag_pipe #(.WIDTH(64), .LANES(1)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data(data64),
        .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags),
        .flush(flush), .out_valid(ov64), .lane_zero(lanes64), .zero(zero64), .flags(flags64));

    zero_flag_pipe #(.WIDTH(64), .LANES(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data(data64),
        .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags),
        .flush(flush), .out_valid(ov4), .lane_zero(lanes4), .zero(zero4), .flags(flags4));

    zero_flag_pipe #(.WIDTH(40), .LANES(1)) dut40 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data(data40),
        .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags),
        .flush(flush), .out_valid(ov40), .lane_zero(lanes40), .zero(zero40), .flags(flags40));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        c;
        logic        v;
        logic        sf;
        logic        exp_zero;
        logic [3:0]  exp_lane;
        logic [3:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic [63:0] data64;
        logic [39:0] data40;
        logic        c;
        logic        v;
        logic        sf;
    } stim_t;

    vec_t  tbl [8];
    stim_t stim_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [63:0] d, input logic [39:0] d40,
                         input logic c, input logic v, input logic sf);
        in_valid    = iv;
        data64      = d;
        data40      = d40;
        carry_in    = c;
        overflow_in = v;
        set_flags   = sf;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One isolated transaction: measure latency on both 64-bit configs, then flags.
    task automatic run_vec(input string tag, input vec_t vr);
        int lat64;
        int lat4;
        lat64 = -1;
        lat4  = -1;
        drive(1'b1, vr.data, vr.data[39:0], vr.c, vr.v, vr.sf);
        for (int s = 1; s <= 7; s++) begin
            cycle();
            if (s == 1) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            if (ov64 && lat64 < 0) begin
                lat64 = s;
                check({tag, "_zero64"}, zero64, vr.exp_zero);
            end
            if (ov4 && lat4 < 0) begin
                lat4 = s;
                check({tag, "_lane4"}, lanes4, vr.exp_lane);
                check({tag, "_zero4"}, zero4, vr.exp_zero);
            end
        end
        check({tag, "_lat64"}, lat64, 4);
        check({tag, "_lat4"}, lat4, 3);
        check({tag, "_flags64"}, flags64, vr.exp_flags);
        check({tag, "_flags4"}, flags4, vr.exp_flags);
    endtask

    // Back-to-back stream from stim_q, checked each cycle against a small model.
    task automatic run_stream(input string tag);
        int    n;
        int    i64;
        int    i4;
        logic  v4;
        logic  pend_v;
        logic  pend_sf;
        logic [3:0] pend_f;
        logic [3:0] exp_l;
        stim_t st;
        n = stim_q.size();
        pend_v = 1'b0;
        pend_sf = 1'b0;
        pend_f = '0;
        for (int t = 0; t < n + 6; t++) begin
            if (t < n) drive(1'b1, stim_q[t].data64, stim_q[t].data40, stim_q[t].c, stim_q[t].v, stim_q[t].sf);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            if (pend_v && pend_sf) mflags = pend_f;
            @(negedge clk);
            i64 = t - 3;
            i4  = t - 2;
            pend_v = (i64 >= 0) && (i64 < n);
            check({tag, "_valid64"}, ov64, pend_v);
            check({tag, "_valid40"}, ov40, pend_v);
            if (pend_v) begin
                st = stim_q[i64];
                check({tag, "_zero64"}, zero64, st.data64 == 64'd0);
                check({tag, "_zero40"}, zero40, st.data40 == 40'd0);
                pend_sf = st.sf;
                pend_f  = {st.data64[63], st.data64 == 64'd0, st.c, st.v};
            end
            v4 = (i4 >= 0) && (i4 < n);
            check({tag, "_valid4"}, ov4, v4);
            if (v4) begin
                st = stim_q[i4];
                for (int j = 0; j < 4; j++) exp_l[j] = (st.data64[16*j +: 16] == 16'd0);
                check({tag, "_lane4"}, lanes4, exp_l);
                check({tag, "_zero4"}, zero4, st.data64 == 64'd0);
            end
            check({tag, "_flags64"}, flags64, mflags);
        end
        stim_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat64;
        int   lat4;
        logic found;
        vec_t pre;

        tbl[0] = '{64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0110};
        tbl[1] = '{64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0111, 4'b1000};
        tbl[2] = '{64'h0000_FFFF_0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, 4'b1000};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1011};
        tbl[4] = '{64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b0000};
        tbl[5] = '{64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0000};
        tbl[6] = '{64'h0000_8000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, 4'b0010};
        tbl[7] = '{64'h0000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b0101};

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid64", ov64, 1'b0);
        check("rst_zero64", zero64, 1'b0);
        check("rst_flags64", flags64, 4'b0000);
        check("rst_lane4", lanes4, 4'b0000);
        check("rst_valid40", ov40, 1'b0);
        reset = 1'b0;

        // Isolated vectors
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end
        mflags = 4'b0101;

        // Single-bit walk, back to back, no flag updates
        for (int b = 0; b < 64; b++) begin
            stim_t s;
            s.data64 = 64'd1 << b;
            s.data40 = s.data64[39:0];
            s.c = 1'b0;
            s.v = 1'b0;
            s.sf = 1'b0;
            stim_q.push_back(s);
        end
        run_stream("walk");
        check("walk_flags_hold", flags64, 4'b0101);

        // Back-to-back 0, 5, 0 with set_flags 0, 1, 0
        stim_q.push_back('{64'd0, 40'd0, 1'b1, 1'b1, 1'b0});
        stim_q.push_back('{64'd5, 40'd5, 1'b0, 1'b0, 1'b1});
        stim_q.push_back('{64'd0, 40'd0, 1'b1, 1'b1, 1'b0});
        run_stream("b2b");
        check("b2b_flags_final", flags64, 4'b0000);

        // Flush kills an in-flight result; next input after flush emerges normally
        drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_valid64_at_flush", ov64, 1'b0);
        drive(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        lat64 = -1;
        lat4  = -1;
        for (int s = 1; s <= 7; s++) begin
            cycle();
            if (s == 1) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            if (ov64 && lat64 < 0) begin
                lat64 = s;
                check("fl_zero64", zero64, 1'b1);
            end
            if (ov4 && lat4 < 0) lat4 = s;
        end
        check("fl_lat64", lat64, 4);
        check("fl_lat4", lat4, 3);
        check("fl_flags64", flags64, 4'b0000);
        check("fl_flags4", flags4, 4'b0000);

        // Flush on the retire edge suppresses the flag write
        drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b1);
        found = 1'b0;
        for (int s = 1; s <= 8 && !found; s++) begin
            cycle();
            if (s == 1) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            if (ov64) found = 1'b1;
        end
        check("fls_found", found, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fls_flags64", flags64, 4'b0000);
        check("fls_flags4", flags4, 4'b0111);
        repeat (3) cycle();

        // 40-bit config with padding in the upper levels
        stim_q.push_back('{64'd0, 40'h00_0000_0000, 1'b0, 1'b0, 1'b0});
        stim_q.push_back('{64'd0, 40'h80_0000_0000, 1'b0, 1'b0, 1'b0});
        stim_q.push_back('{64'd0, 40'h00_0000_0001, 1'b0, 1'b0, 1'b0});
        stim_q.push_back('{64'd0, 40'h00_0000_0000, 1'b0, 1'b0, 1'b0});
        run_stream("w40");

        // Reset with results in flight
        pre = '{64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0110};
        run_vec("prerst", pre);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b1);
            cycle();
        end
        check("rst2_pre_valid4", ov4, 1'b1);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("rst2_valid64", ov64, 1'b0);
        check("rst2_valid4", ov4, 1'b0);
        check("rst2_flags64", flags64, 4'b0000);
        check("rst2_flags4", flags4, 4'b0000);
        check("rst2_zero64", zero64, 1'b0);
        check("rst2_zero4", zero4, 1'b0);
        check("rst2_zero40", zero40, 1'b0);
        check("rst2_lane4", lanes4, 4'b0000);
        reset = 1'b0;
        for (int s = 0; s < 6; s++) begin
            cycle();
            check("rst2_no_valid64", ov64, 1'b0);
            check("rst2_no_valid4", ov4, 1'b0);
            check("rst2_no_valid40", ov40, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
